hier_node_sequencer: RTL and testbench
======================================

Name: hier_node_sequencer

Overview:
- Parametrised hierarchy node: owns NUM_CHILDREN child blocks and sequences them from a single parent start.
- Replaces the fixed five-child, portless structural node with a start/done/error handshake towards the parent and each child.
- Launches children one at a time (sequential mode) or all at once (parallel mode), with a per-wait timeout.
- Reports one aggregate done/error upward, so nodes chain into arbitrarily deep trees.

Parameters:
- NUM_CHILDREN, 5, number of child slots (1..32).
- PARALLEL, 0, 0 = sequential launch in ascending index order, 1 = launch all enabled children together.
- TIMEOUT_W, 16, width of the timeout limit and the timeout counter.
- IDX_W, $clog2(NUM_CHILDREN) min 1, width of the child index (derived; do not override).

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start_i  in  1  parent start request; accepted only in IDLE.
- child_en_i  in  NUM_CHILDREN  mask of children taking part; latched when start is accepted.
- timeout_i  in  TIMEOUT_W  maximum cycles to wait for a done; 0 disables the timeout.
- busy_o  out  1  high from the cycle after an accepted start until the cycle after done_o.
- done_o  out  1  single-cycle completion pulse to the parent.
- err_o  out  1  run failed (child error or timeout); valid with done_o, held until the next accepted start.
- err_timeout_o  out  1  the failure was a timeout; same validity as err_o.
- err_child_o  out  IDX_W  index of the failing child; same validity as err_o.
- child_start_o  out  NUM_CHILDREN  one-cycle start pulse per child.
- child_done_i  in  NUM_CHILDREN  one-cycle done pulse from each child.
- child_err_i  in  NUM_CHILDREN  child error, sampled only together with that child's done.

Behaviour:
- Reset: all outputs 0, state IDLE, latched mask, index and counter cleared. Reset mid-run aborts immediately; child_start_o is never issued in or after the reset cycle.
- States: IDLE, LAUNCH, WAIT, FINISH.
- Outputs decode from registers only; there is no combinational path from any input to any output.
- IDLE:
  - start_i=1 at edge T: latch en_mask=child_en_i, clear done_mask, err_o, err_timeout_o and err_child_o.
  - Sequential: idx = lowest enabled index.
  - If en_mask==0, go to FINISH; else go to LAUNCH.
  - start_i outside IDLE is ignored (no queuing).
- LAUNCH (one cycle):
  - Sequential: child_start_o[idx]=1.
  - Parallel: child_start_o=en_mask.
  - Go to WAIT; timeout counter cleared to 0.
  - Latency: start_i sampled at T gives child_start_o in cycle T+1.
- WAIT:
  - Counter increments each cycle.
  - child_done_i is accepted only for launched, not-yet-done children; all other done pulses are ignored. Children must not respond in their own LAUNCH cycle.
  - Sequential, done[idx] seen:
    - child_err_i[idx]=1: set err_o, err_child_o=idx, skip the remaining children, go to FINISH.
    - Otherwise: idx = next enabled index > idx, go to LAUNCH; if none remain, go to FINISH.
  - Parallel: OR accepted dones into done_mask.
    - Any accepted child error sets err_o; err_child_o takes the lowest erroring index seen so far.
    - When done_mask==en_mask (including dones arriving this cycle), go to FINISH.
  - Timeout: timeout_i!=0, counter==timeout_i-1, and the completing done is absent: set err_o and err_timeout_o, go to FINISH.
    - err_child_o = idx (sequential) or lowest pending index (parallel).
    - A completing done in the same cycle wins over the timeout.
- FINISH (one cycle): done_o=1, busy_o still 1; next state IDLE.
- busy_o = (state!=IDLE), registered.
- Index and counter arithmetic never wraps: the counter saturates at all-ones, and idx is compared only against NUM_CHILDREN-1.

Decomposition:
- Package hier_node_pkg: state enum node_state_e {IDLE, LAUNCH, WAIT, FINISH}, and a mode constant MODE_SEQ/MODE_PAR.
- Sub-module hier_node_prio_enc: parametrised lowest-set-bit finder with a "start above index" input. It is used for the next-enabled-child, lowest-error and lowest-pending lookups.

Test Plan:
- Sequential, N=5, en=5'b10101, each child replies with done 3 cycles after its start -> starts on children 0, 2, 4 in order; done_o 1 cycle after child 4's done; err_o=0.
- Sequential, en=5'b01111, child 1 replies with done+err -> children 2 and 3 never started; done_o next cycle; err_o=1, err_child_o=1, err_timeout_o=0.
- Parallel, en=5'b11111, dones arrive in order 4, 0, 3, 1, 2 with child 3 erroring -> a single start cycle on all five; done_o after child 2's done; err_o=1, err_child_o=3.
- timeout_i=8, child 0 never responds -> in the 8th WAIT cycle err_timeout_o=1, err_child_o=0; done_o the next cycle. Repeat with the done arriving in exactly that cycle -> no error.
- en=0 -> done_o at T+1, no child_start_o. start_i while busy, and stray dones from unlaunched children -> both ignored.
- rst asserted in the middle of WAIT -> next cycle all outputs are 0; a new start runs cleanly.

Source files
------------

// File: rtl/hier_node_pkg.sv
// rtl/hier_node_pkg.sv - shared state type and launch-mode constants for the hierarchy node sequencer
//
// Contents:
//   node_state_e  sequencer state: IDLE, LAUNCH, WAIT, FINISH
//   MODE_SEQ      PARALLEL value selecting one-at-a-time launch in ascending index order
//   MODE_PAR      PARALLEL value selecting a single launch of every enabled child
package hier_node_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    FINISH = 2'd3
  } node_state_e;

  localparam int MODE_SEQ = 0;
  localparam int MODE_PAR = 1;

endpackage

// File: rtl/hier_node_prio_enc.sv
// rtl/hier_node_prio_enc.sv - lowest-set-bit finder restricted to indices at or above a start index
//
// Parameters:
//   WIDTH  number of request bits
//   IDX_W  width of the start and result indices
// Ports:
//   req    in   WIDTH  candidate bits
//   from   in   IDX_W  lowest index that may be reported
//   found  out  1      some req bit at index >= from is set
//   idx    out  IDX_W  lowest such index (0 when nothing is found)
module hier_node_prio_enc #(
  parameter int WIDTH = 5,
  parameter int IDX_W = 3
) (
  input  logic [WIDTH-1:0] req,
  input  logic [IDX_W-1:0] from,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  // Scan from the top down so the last match written is the lowest index.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (req[i] && (i >= int'(from))) begin
        found = 1'b1;
        idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/hier_node_sequencer.sv
// rtl/hier_node_sequencer.sv - hierarchy node that launches its children from one parent start and reports one aggregate done/error
//
// Parameters:
//   NUM_CHILDREN  number of child slots (1..32)
//   PARALLEL      MODE_SEQ: launch one child at a time in ascending order; MODE_PAR: launch all enabled children together
//   TIMEOUT_W     width of the timeout limit and the wait counter
//   IDX_W         child index width (derived)
// Ports:
//   clk            in   1             rising-edge clock
//   rst            in   1             synchronous active-high reset
//   start_i        in   1             parent start, accepted only when idle
//   child_en_i     in   NUM_CHILDREN  children taking part, latched on an accepted start
//   timeout_i      in   TIMEOUT_W     cycles to wait for a done; 0 waits forever
//   busy_o         out  1             run in progress (through the done_o cycle)
//   done_o         out  1             one-cycle completion pulse
//   err_o          out  1             run failed; held until the next accepted start
//   err_timeout_o  out  1             the failure was a timeout
//   err_child_o    out  IDX_W         index of the failing child
//   child_start_o  out  NUM_CHILDREN  one-cycle start pulse per child
//   child_done_i   in   NUM_CHILDREN  one-cycle done pulse per child
//   child_err_i    in   NUM_CHILDREN  child error, qualified by that child's done
module hier_node_sequencer
  import hier_node_pkg::*;
#(
  parameter int NUM_CHILDREN = 5,
  parameter int PARALLEL     = 0,
  parameter int TIMEOUT_W    = 16,
  parameter int IDX_W        = (NUM_CHILDREN > 1) ? $clog2(NUM_CHILDREN) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_i,
  input  logic [NUM_CHILDREN-1:0] child_en_i,
  input  logic [TIMEOUT_W-1:0]    timeout_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    err_o,
  output logic                    err_timeout_o,
  output logic [IDX_W-1:0]        err_child_o,
  output logic [NUM_CHILDREN-1:0] child_start_o,
  input  logic [NUM_CHILDREN-1:0] child_done_i,
  input  logic [NUM_CHILDREN-1:0] child_err_i
);

  localparam logic [NUM_CHILDREN-1:0] ONE      = NUM_CHILDREN'(1);
  localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(NUM_CHILDREN - 1);
  localparam bit                      PAR_MODE = (PARALLEL == MODE_PAR);

  node_state_e             state;
  logic [NUM_CHILDREN-1:0] en_mask;
  logic [NUM_CHILDREN-1:0] done_mask;
  logic [IDX_W-1:0]        idx;
  logic [TIMEOUT_W-1:0]    cnt;

  logic [NUM_CHILDREN-1:0] sel;
  logic [NUM_CHILDREN-1:0] accepted;
  logic [NUM_CHILDREN-1:0] acc_err;
  logic [NUM_CHILDREN-1:0] done_all;
  logic [NUM_CHILDREN-1:0] pending;
  logic [NUM_CHILDREN-1:0] next_req;
  logic [IDX_W-1:0]        next_from;
  logic [IDX_W-1:0]        next_idx;
  logic [IDX_W-1:0]        err_idx;
  logic [IDX_W-1:0]        pend_idx;
  logic                    next_found;
  logic                    err_found;
  logic                    pend_found;
  logic                    timed_out;
  logic                    all_done;
  logic                    seq_hit;

  always_comb begin
    sel = ONE << idx;

    // Only dones from launched, still-outstanding children count, and only while waiting.
    accepted = '0;
    if (state == WAIT) begin
      if (PAR_MODE) begin
        accepted = child_done_i & en_mask & ~done_mask;
      end else begin
        accepted = child_done_i & sel;
      end
    end
    acc_err  = accepted & child_err_i;
    done_all = done_mask | accepted;
    pending  = en_mask & ~done_all;
    all_done = (done_all == en_mask);
    seq_hit  = |accepted;

    timed_out = (timeout_i != '0) && (cnt == timeout_i - TIMEOUT_W'(1));

    // Idle: first enabled child of the incoming mask. Otherwise: next enabled child
    // above idx; idx is never incremented past the last slot, so nothing wraps.
    if (state == IDLE) begin
      next_req  = child_en_i;
      next_from = '0;
    end else if (idx == LAST_IDX) begin
      next_req  = '0;
      next_from = '0;
    end else begin
      next_req  = en_mask;
      next_from = idx + IDX_W'(1);
    end
  end

  hier_node_prio_enc #(.WIDTH(NUM_CHILDREN), .IDX_W(IDX_W)) u_next_enc (
    .req   (next_req),
    .from  (next_from),
    .found (next_found),
    .idx   (next_idx)
  );

  hier_node_prio_enc #(.WIDTH(NUM_CHILDREN), .IDX_W(IDX_W)) u_err_enc (
    .req   (acc_err),
    .from  ('0),
    .found (err_found),
    .idx   (err_idx)
  );

  hier_node_prio_enc #(.WIDTH(NUM_CHILDREN), .IDX_W(IDX_W)) u_pend_enc (
    .req   (pending),
    .from  ('0),
    .found (pend_found),
    .idx   (pend_idx)
  );

  // All outputs are registered and written together with the state that they belong to,
  // so child_start_o appears in the LAUNCH cycle and done_o in the FINISH cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      en_mask       <= '0;
      done_mask     <= '0;
      idx           <= '0;
      cnt           <= '0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      err_o         <= 1'b0;
      err_timeout_o <= 1'b0;
      err_child_o   <= '0;
      child_start_o <= '0;
    end else begin
      child_start_o <= '0;
      done_o        <= 1'b0;

      case (state)
        IDLE: begin
          if (start_i) begin
            en_mask       <= child_en_i;
            done_mask     <= '0;
            err_o         <= 1'b0;
            err_timeout_o <= 1'b0;
            err_child_o   <= '0;
            idx           <= next_idx;
            busy_o        <= 1'b1;
            if (child_en_i == '0) begin
              state  <= FINISH;
              done_o <= 1'b1;
            end else begin
              state         <= LAUNCH;
              child_start_o <= PAR_MODE ? child_en_i : (ONE << next_idx);
            end
          end
        end

        LAUNCH: begin
          state <= WAIT;
          cnt   <= '0;
        end

        WAIT: begin
          if (cnt != '1) begin
            cnt <= cnt + TIMEOUT_W'(1);
          end

          if (PAR_MODE) begin
            done_mask <= done_all;
            if (err_found && (!err_o || (err_idx < err_child_o))) begin
              err_o       <= 1'b1;
              err_child_o <= err_idx;
            end
            // A completing done beats a timeout in the same cycle.
            if (all_done) begin
              state  <= FINISH;
              done_o <= 1'b1;
            end else if (timed_out && pend_found) begin
              err_o         <= 1'b1;
              err_timeout_o <= 1'b1;
              err_child_o   <= pend_idx;
              state         <= FINISH;
              done_o        <= 1'b1;
            end
          end else begin
            if (seq_hit) begin
              if (|acc_err) begin
                // Child failure skips every remaining child.
                err_o       <= 1'b1;
                err_child_o <= idx;
                state       <= FINISH;
                done_o      <= 1'b1;
              end else if (next_found) begin
                idx           <= next_idx;
                child_start_o <= ONE << next_idx;
                state         <= LAUNCH;
              end else begin
                state  <= FINISH;
                done_o <= 1'b1;
              end
            end else if (timed_out) begin
              err_o         <= 1'b1;
              err_timeout_o <= 1'b1;
              err_child_o   <= idx;
              state         <= FINISH;
              done_o        <= 1'b1;
            end
          end
        end

        FINISH: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end

        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hier_node_sequencer.sv
// tb/tb_hier_node_sequencer.sv - self-checking bench for hier_node_sequencer in sequential and parallel modes
module tb_hier_node_sequencer;

  localparam int N     = 5;
  localparam int BOUND = 200;

  logic        clk;
  logic        rst;
  logic        start       [2];
  logic [4:0]  child_en    [2];
  logic [15:0] timeout     [2];
  logic        busy        [2];
  logic        done        [2];
  logic        err         [2];
  logic        err_tmo     [2];
  logic [2:0]  err_child   [2];
  logic [4:0]  child_start [2];
  logic [4:0]  child_done  [2];
  logic [4:0]  child_err   [2];

  hier_node_sequencer #(.NUM_CHILDREN(N), .PARALLEL(0), .TIMEOUT_W(16)) dut_seq (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start[0]),
    .child_en_i    (child_en[0]),
    .timeout_i     (timeout[0]),
    .busy_o        (busy[0]),
    .done_o        (done[0]),
    .err_o         (err[0]),
    .err_timeout_o (err_tmo[0]),
    .err_child_o   (err_child[0]),
    .child_start_o (child_start[0]),
    .child_done_i  (child_done[0]),
    .child_err_i   (child_err[0])
  );

  hier_node_sequencer #(.NUM_CHILDREN(N), .PARALLEL(1), .TIMEOUT_W(16)) dut_par (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start[1]),
    .child_en_i    (child_en[1]),
    .timeout_i     (timeout[1]),
    .busy_o        (busy[1]),
    .done_o        (done[1]),
    .err_o         (err[1]),
    .err_timeout_o (err_tmo[1]),
    .err_child_o   (err_child[1]),
    .child_start_o (child_start[1]),
    .child_done_i  (child_done[1]),
    .child_err_i   (child_err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Per-run child behaviour: latency from start to done (-1 = never answers), error flag.
  int         cur_lat [5];
  logic [4:0] cur_err;

  int obs_done, obs_idx;
  bit obs_err, obs_tmo, obs_multi, obs_busy_ok;
  bit after_busy, after_done, after_err;
  int obs_start [5];

  int exp_done, exp_idx;
  bit exp_err, exp_tmo;
  int exp_start [5];

  typedef struct {
    int         mode;
    logic [4:0] en;
    int         lat [5];
    logic [4:0] errm;
    int         tmo;
    int         exp_done;
    bit         exp_err;
    bit         exp_tmo;
    int         exp_idx;
    int         exp_start [5];
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, req);
    end
  endtask

  // Reference: cycle numbers count from the edge that accepts start (cycle 1 follows it).
  task automatic model(input int m, input logic [4:0] en, input int tmo);
    int t, mx, pend, low_err;
    for (int i = 0; i < 5; i++) exp_start[i] = 0;
    exp_err = 0; exp_tmo = 0; exp_idx = 0;
    if (en == 5'b0) begin
      exp_done = 1;
      return;
    end
    if (m == 0) begin
      t = 1;
      for (int i = 0; i < 5; i++) begin
        if (en[i]) begin
          exp_start[i] = t;
          if (cur_lat[i] > 0 && (tmo == 0 || cur_lat[i] <= tmo)) begin
            if (cur_err[i]) begin
              exp_done = t + cur_lat[i] + 1; exp_err = 1; exp_idx = i;
              return;
            end
            t = t + cur_lat[i] + 1;
          end else begin
            exp_done = t + tmo + 1; exp_err = 1; exp_tmo = 1; exp_idx = i;
            return;
          end
        end
      end
      exp_done = t;
    end else begin
      mx = 0; pend = -1; low_err = -1;
      for (int i = 0; i < 5; i++) begin
        if (en[i]) begin
          exp_start[i] = 1;
          if (cur_lat[i] > 0 && (tmo == 0 || cur_lat[i] <= tmo)) begin
            if (cur_lat[i] > mx) mx = cur_lat[i];
            if (cur_err[i] && low_err < 0) low_err = i;
          end else if (pend < 0) begin
            pend = i;
          end
        end
      end
      if (pend >= 0) begin
        exp_done = tmo + 2; exp_err = 1; exp_tmo = 1; exp_idx = pend;
      end else begin
        exp_done = mx + 2;
        if (low_err >= 0) begin exp_err = 1; exp_idx = low_err; end
      end
    end
  endtask

  // Drives one run on instance m, playing the children and optionally injecting
  // ignored traffic: start pulses while busy, mask changes, dones from disabled children.
  task automatic run_case(input int m, input logic [4:0] en, input int tmo, input bit noise);
    int         done_at [5];
    int         cyc;
    bit         got;
    logic [4:0] d, e, nz;
    for (int i = 0; i < 5; i++) begin done_at[i] = -1; obs_start[i] = 0; end
    obs_multi = 0; obs_busy_ok = 1; obs_done = -1;
    obs_err = 0; obs_tmo = 0; obs_idx = 0;
    @(negedge clk);
    start[m] = 1'b1; child_en[m] = en; timeout[m] = 16'(tmo);
    @(negedge clk);
    start[m] = 1'b0;
    cyc = 1; got = 0;
    while (!got && cyc <= BOUND) begin
      d = '0; e = '0;
      for (int i = 0; i < 5; i++) begin
        if (done_at[i] == cyc) begin d[i] = 1'b1; e[i] = cur_err[i]; end
      end
      if (noise) begin
        nz = 5'($urandom) & ~en;
        d = d | nz;
        e = e | (nz & 5'($urandom));
        start[m] = ($urandom_range(0, 3) == 0);
        child_en[m] = 5'($urandom);
      end
      child_done[m] = d; child_err[m] = e;
      if (!busy[m]) obs_busy_ok = 0;
      for (int i = 0; i < 5; i++) begin
        if (child_start[m][i]) begin
          if (obs_start[i] != 0) obs_multi = 1;
          obs_start[i] = cyc;
          if (cur_lat[i] > 0) done_at[i] = cyc + cur_lat[i];
        end
      end
      if (done[m]) begin
        got = 1; obs_done = cyc;
        obs_err = err[m]; obs_tmo = err_tmo[m]; obs_idx = int'(err_child[m]);
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    start[m] = 1'b0; child_done[m] = '0; child_err[m] = '0;
    @(negedge clk);
    after_busy = busy[m]; after_done = done[m]; after_err = err[m];
  endtask

  task automatic compare_run(input string tag);
    check({tag, "_done_cycle"}, obs_done, exp_done);
    check({tag, "_err"}, int'(obs_err), int'(exp_err));
    check({tag, "_err_timeout"}, int'(obs_tmo), int'(exp_tmo));
    check({tag, "_err_child"}, obs_idx, exp_idx);
    for (int i = 0; i < 5; i++)
      check($sformatf("%s_start_cycle%0d", tag, i), obs_start[i], exp_start[i]);
    check({tag, "_repeat_start"}, int'(obs_multi), 0);
    check({tag, "_busy_during"}, int'(obs_busy_ok), 1);
    check({tag, "_busy_after"}, int'(after_busy), 0);
    check({tag, "_done_pulse_width"}, int'(after_done), 0);
    check({tag, "_err_held"}, int'(after_err), int'(exp_err));
  endtask

  function automatic int outs_or(input int m);
    return int'(busy[m] | done[m] | err[m] | err_tmo[m] | (|err_child[m]) | (|child_start[m]));
  endfunction

  initial begin
    int         m, tmo;
    logic [4:0] en;

    vecs[0]  = '{0, 5'b10101, '{3, 3, 3, 3, 3},  5'b00000, 0, 13, 1'b0, 1'b0, 0, '{1, 0, 5, 0, 9}};
    vecs[1]  = '{0, 5'b01111, '{3, 3, 3, 3, 3},  5'b00010, 0,  9, 1'b1, 1'b0, 1, '{1, 5, 0, 0, 0}};
    vecs[2]  = '{1, 5'b11111, '{3, 5, 6, 4, 2},  5'b01000, 0,  8, 1'b1, 1'b0, 3, '{1, 1, 1, 1, 1}};
    vecs[3]  = '{0, 5'b00001, '{-1, 3, 3, 3, 3}, 5'b00000, 8, 10, 1'b1, 1'b1, 0, '{1, 0, 0, 0, 0}};
    vecs[4]  = '{0, 5'b00001, '{8, 3, 3, 3, 3},  5'b00000, 8, 10, 1'b0, 1'b0, 0, '{1, 0, 0, 0, 0}};
    vecs[5]  = '{0, 5'b00000, '{3, 3, 3, 3, 3},  5'b00000, 0,  1, 1'b0, 1'b0, 0, '{0, 0, 0, 0, 0}};
    vecs[6]  = '{1, 5'b00000, '{3, 3, 3, 3, 3},  5'b00000, 0,  1, 1'b0, 1'b0, 0, '{0, 0, 0, 0, 0}};
    vecs[7]  = '{1, 5'b11010, '{3, 2, 3, -1, -1}, 5'b00000, 5, 7, 1'b1, 1'b1, 3, '{0, 1, 0, 1, 1}};
    vecs[8]  = '{0, 5'b00110, '{3, 2, -1, 3, 3}, 5'b00000, 4,  9, 1'b1, 1'b1, 2, '{0, 1, 4, 0, 0}};
    vecs[9]  = '{0, 5'b10000, '{1, 1, 1, 1, 1},  5'b00000, 1,  3, 1'b0, 1'b0, 0, '{0, 0, 0, 0, 1}};
    vecs[10] = '{1, 5'b11111, '{4, 3, 4, 4, 2},  5'b10010, 0,  6, 1'b1, 1'b0, 1, '{1, 1, 1, 1, 1}};
    vecs[11] = '{1, 5'b00001, '{8, 3, 3, 3, 3},  5'b00000, 8, 10, 1'b0, 1'b0, 0, '{1, 0, 0, 0, 0}};

    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      start[k] = 1'b0; child_en[k] = '0; timeout[k] = '0;
      child_done[k] = '0; child_err[k] = '0;
    end
    repeat (3) @(negedge clk);
    check("reset_outputs_seq", outs_or(0), 0);
    check("reset_outputs_par", outs_or(1), 0);
    rst = 1'b0;

    for (int v = 0; v < 12; v++) begin
      for (int i = 0; i < 5; i++) cur_lat[i] = vecs[v].lat[i];
      cur_err   = vecs[v].errm;
      exp_done  = vecs[v].exp_done;
      exp_err   = vecs[v].exp_err;
      exp_tmo   = vecs[v].exp_tmo;
      exp_idx   = vecs[v].exp_idx;
      for (int i = 0; i < 5; i++) exp_start[i] = vecs[v].exp_start[i];
      run_case(vecs[v].mode, vecs[v].en, vecs[v].tmo, (v % 2) == 0);
      compare_run($sformatf("vec%0d", v));
    end

    // Reset while a sequential run waits on a silent child.
    cur_lat = '{-1, -1, -1, -1, -1};
    cur_err = '0;
    @(negedge clk);
    start[0] = 1'b1; child_en[0] = 5'b00001; timeout[0] = '0;
    @(negedge clk);
    start[0] = 1'b0;
    check("rst_run_launch", int'(child_start[0]), 1);
    repeat (4) @(negedge clk);
    check("rst_run_busy_in_wait", int'(busy[0]), 1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_wait_outputs", outs_or(0), 0);
    // Start presented together with reset must not launch anything.
    start[0] = 1'b1; child_en[0] = 5'b00011;
    @(negedge clk);
    check("rst_with_start_outputs", outs_or(0), 0);
    start[0] = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("after_rst_idle", outs_or(0), 0);

    // A clean run straight after the reset.
    cur_lat = '{3, 3, 3, 3, 3};
    cur_err = '0;
    model(0, 5'b10101, 0);
    run_case(0, 5'b10101, 0, 1'b0);
    compare_run("post_rst");

    for (int r = 0; r < 40; r++) begin
      m   = int'($urandom_range(0, 1));
      tmo = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 7));
      en  = 5'($urandom);
      if ($urandom_range(0, 9) == 0) en = '0;
      for (int i = 0; i < 5; i++)
        cur_lat[i] = (tmo != 0 && $urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(1, 8));
      cur_err = 5'($urandom) & 5'($urandom) & 5'($urandom);
      model(m, en, tmo);
      run_case(m, en, tmo, 1'b1);
      compare_run($sformatf("rnd%0d_m%0d", r, m));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
